bp_lce_lock_ctrl: RTL and testbench

BP_LCE_LOCK_CTRL -- requirements
Module: bp_lce_lock_ctrl

---
 rtl/bp_me_pkg.sv | 18 +
 rtl/bp_lce_lock_ctrl_if.sv | 39 +++
 rtl/bp_lce_lock_timer.sv | 30 +++
 rtl/bsg_counter_up_down.sv | 29 ++
 rtl/bp_lce_lock_ctrl.sv | 122 ++++++++++++
 tb/tb_bp_lce_lock_ctrl.sv | 181 ++++++++++++++++++
 6 files changed

// File: rtl/bp_me_pkg.sv
// Shared LCE/ME types: lock-controller state encoding and counter sizing helper.
// Latency: n/a (types only); backpressure: n/a.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_init = 2'd0,
    e_run  = 2'd1,
    e_lock = 2'd2
  } bp_lce_lock_state_e;

  localparam int lce_lock_stats_width_gp = 32;

  // Bits needed to hold 0..max_val inclusive, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bp_lce_lock_ctrl_if.sv
// Lock-controller sideband bundle; timeout_count_o exists only with BP_LCE_LOCK_STATS_EN.
// Latency: n/a; backpressure: none, all signals are per-cycle levels or pulses.
interface bp_lce_lock_ctrl_if #(parameter int num_ports_p = 3);

  logic                   cache_init_done_i;
  logic                   req_busy_i;
  logic [num_ports_p-1:0] pkt_v_i;
  logic [num_ports_p-1:0] pkt_yumi_i;
  logic                   credit_alloc_i;
  logic                   credit_return_i;
  logic                   lock_o;
  logic                   timeout_o;
  logic                   credits_full_o;
  logic                   credits_empty_o;
`ifdef BP_LCE_LOCK_STATS_EN
  logic [31:0]            timeout_count_o;
`endif

`ifdef BP_LCE_LOCK_STATS_EN
  modport slave (
    input  cache_init_done_i, req_busy_i, pkt_v_i, pkt_yumi_i, credit_alloc_i, credit_return_i,
    output lock_o, timeout_o, credits_full_o, credits_empty_o, timeout_count_o
  );
  modport master (
    output cache_init_done_i, req_busy_i, pkt_v_i, pkt_yumi_i, credit_alloc_i, credit_return_i,
    input  lock_o, timeout_o, credits_full_o, credits_empty_o, timeout_count_o
  );
`else
  modport slave (
    input  cache_init_done_i, req_busy_i, pkt_v_i, pkt_yumi_i, credit_alloc_i, credit_return_i,
    output lock_o, timeout_o, credits_full_o, credits_empty_o
  );
  modport master (
    output cache_init_done_i, req_busy_i, pkt_v_i, pkt_yumi_i, credit_alloc_i, credit_return_i,
    input  lock_o, timeout_o, credits_full_o, credits_empty_o
  );
`endif

endinterface

// File: rtl/bp_lce_lock_timer.sv
// Saturating up-counter with synchronous clear; clear wins over up.
// Latency: count_o updates one cycle after up_i/clear_i; backpressure: none.
module bp_lce_lock_timer
  import bp_me_pkg::*;
#(
  parameter int max_p  = 4,
  parameter int init_p = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic                         up_i,
  output logic [cnt_width(max_p)-1:0]  count_o
);

  localparam int width_lp = cnt_width(max_p);
  localparam logic [width_lp-1:0] max_lp  = width_lp'(max_p);
  localparam logic [width_lp-1:0] init_lp = width_lp'(init_p);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= init_lp;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (up_i && (count_o != max_lp)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_counter_up_down.sv
// Up/down counter; simultaneous up and down cancel. Caller keeps it in range.
// Latency: count_o updates one cycle after up_i/down_i; backpressure: none.
module bsg_counter_up_down
  import bp_me_pkg::*;
#(
  parameter int max_val_p  = 8,
  parameter int init_val_p = 0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            up_i,
  input  logic                            down_i,
  output logic [cnt_width(max_val_p)-1:0] count_o
);

  localparam int width_lp = cnt_width(max_val_p);
  localparam logic [width_lp-1:0] init_lp = width_lp'(init_val_p);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= init_lp;
    end else if (up_i && !down_i) begin
      count_o <= count_o + 1'b1;
    end else if (down_i && !up_i) begin
      count_o <= count_o - 1'b1;
    end
  end

endmodule

// File: rtl/bp_lce_lock_ctrl.sv
// LCE request lock hint: forces a lock after sustained port blocking, tracks request credits (BP_LCE_LOCK_STATS_EN adds timeout_count_o).
// Latency: lock_o/timeout_o combinational from state and inputs; backpressure: none, lock_o is the hint upstream throttles on.
module bp_lce_lock_ctrl
  import bp_me_pkg::*;
#(
  parameter int num_ports_p         = 3,
  parameter int timeout_max_limit_p = 4,
  parameter int lock_hold_p         = 1,
  parameter int credits_p           = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  bp_lce_lock_ctrl_if.slave io
);

  localparam int blk_w_lp  = cnt_width(timeout_max_limit_p);
  localparam int hold_w_lp = cnt_width(lock_hold_p);
  localparam int cred_w_lp = cnt_width(credits_p);
  localparam logic [blk_w_lp-1:0]  blk_max_lp  = blk_w_lp'(timeout_max_limit_p);
  localparam logic [hold_w_lp-1:0] hold_max_lp = hold_w_lp'(lock_hold_p);
  localparam logic [cred_w_lp-1:0] cred_max_lp = cred_w_lp'(credits_p);

  bp_lce_lock_state_e    state_r, state_n;
  logic                  blocked;
  logic                  timeout;
  logic                  lock;
  logic [blk_w_lp-1:0]   blk_cnt;
  logic [hold_w_lp-1:0]  hold_elapsed;
  logic [hold_w_lp-1:0]  hold_cnt;
  logic [cred_w_lp-1:0]  credit_cnt;
  logic                  credits_full;
  logic                  credits_empty;
  logic                  credit_up;
  logic                  credit_down;

  assign blocked = |(io.pkt_v_i[num_ports_p-1:0] & ~io.pkt_yumi_i[num_ports_p-1:0]);

  bp_lce_lock_timer #(.max_p(timeout_max_limit_p), .init_p(0)) blk_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i ((state_r != e_run) | ~blocked | timeout),
    .up_i    (blocked),
    .count_o (blk_cnt)
  );

  // Hold is tracked as elapsed lock cycles; starting saturated makes hold_cnt read 0 out of reset.
  bp_lce_lock_timer #(.max_p(lock_hold_p), .init_p(lock_hold_p)) hold_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (timeout),
    .up_i    (state_r == e_lock),
    .count_o (hold_elapsed)
  );

  assign hold_cnt = hold_max_lp - hold_elapsed;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_init;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_init:  if (io.cache_init_done_i)           state_n = e_run;
      e_run:   if (timeout)                        state_n = e_lock;
      e_lock:  if ((hold_cnt == '0) && !blocked)   state_n = e_run;
      default:                                     state_n = e_init;
    endcase
  end

  // Timeout is masked during reset so an in-flight count never leaks a pulse.
  always_comb begin
    timeout       = (state_r == e_run) && (blk_cnt == blk_max_lp) && !reset_i;
    lock          = (state_r != e_run) | timeout | io.req_busy_i | ~io.cache_init_done_i;
    credits_full  = (credit_cnt == cred_max_lp);
    credits_empty = (credit_cnt == '0);
  end

  assign io.lock_o          = lock;
  assign io.timeout_o       = timeout;
  assign io.credits_full_o  = credits_full;
  assign io.credits_empty_o = credits_empty;

  assign credit_up   = io.credit_alloc_i  & ~io.credit_return_i & ~credits_full;
  assign credit_down = io.credit_return_i & ~io.credit_alloc_i  & ~credits_empty;

  bsg_counter_up_down #(.max_val_p(credits_p), .init_val_p(0)) credit_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (credit_up),
    .down_i  (credit_down),
    .count_o (credit_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io.credit_alloc_i && !io.credit_return_i && credits_full))
        else $warning("bp_lce_lock_ctrl: credit alloc while full, count held");
      assert (!(io.credit_return_i && !io.credit_alloc_i && credits_empty))
        else $warning("bp_lce_lock_ctrl: credit return while empty, count held");
    end
  end

`ifdef BP_LCE_LOCK_STATS_EN
  logic [lce_lock_stats_width_gp-1:0] timeout_count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timeout_count_r <= '0;
    end else if (timeout && (timeout_count_r != '1)) begin
      timeout_count_r <= timeout_count_r + 1'b1;
    end
  end

  assign io.timeout_count_o = timeout_count_r;
`endif

endmodule

// File: tb/tb_bp_lce_lock_ctrl.sv
// Directed bench for bp_lce_lock_ctrl with a per-cycle expectation scoreboard.
// Expected bits per cycle are {lock_o, timeout_o, credits_full_o, credits_empty_o} under a care mask.
module tb_bp_lce_lock_ctrl;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  bp_lce_lock_ctrl_if #(.num_ports_p(3)) bus ();

  bp_lce_lock_ctrl #(
    .num_ports_p         (3),
    .timeout_max_limit_p (4),
    .lock_hold_p         (2),
    .credits_p           (2)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .io      (bus)
  );

  typedef struct {
    int         tag;
    logic [3:0] m;
    logic [3:0] e;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_n   = 0;

  function automatic string sig_name(input int i);
    case (i)
      3:       return "lock_o";
      2:       return "timeout_o";
      1:       return "credits_full_o";
      default: return "credits_empty_o";
    endcase
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show during it.
  task automatic cyc(input logic rst, input logic init_done, input logic busy,
                     input logic [2:0] v, input logic [2:0] y,
                     input logic al, input logic rt,
                     input logic [3:0] m, input logic [3:0] e);
    exp_t x;
    reset_i               = rst;
    bus.cache_init_done_i = init_done;
    bus.req_busy_i        = busy;
    bus.pkt_v_i           = v;
    bus.pkt_yumi_i        = y;
    bus.credit_alloc_i    = al;
    bus.credit_return_i   = rt;
    x.tag = step_n;
    x.m   = m;
    x.e   = e;
    sb_q.push_back(x);
    step_n++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: one popped expectation per cycle, compared mid-cycle.
  initial begin
    exp_t       x;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x   = sb_q.pop_front();
        act = {bus.lock_o, bus.timeout_o, bus.credits_full_o, bus.credits_empty_o};
        for (int i = 3; i >= 0; i--) begin
          if (x.m[i]) begin
            checks++;
            if (act[i] !== x.e[i]) begin
              failures++;
              $display("FAIL step%0d %s got=%b want=%b", x.tag, sig_name(i), act[i], x.e[i]);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cache_init_done_i = 1'b0;
    bus.req_busy_i        = 1'b0;
    bus.pkt_v_i           = '0;
    bus.pkt_yumi_i        = '0;
    bus.credit_alloc_i    = 1'b0;
    bus.credit_return_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then init with done low for 5 cycles.
    cyc(1, 0, 0, 3'b000, 3'b000, 0, 0, 4'b1111, 4'b1001);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 3'b000, 3'b000, 0, 0, 4'b1111, 4'b1001);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1111, 4'b1001);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1111, 4'b0001);

    // Sustained block on port 1: timeout on 5th cycle, hold of 2, release after block ends.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b0000);
    cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b1100);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b1000);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b1000);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b0000);

    // Block 3, accept on port 1, block again: count restarts.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b0000);
    cyc(0, 1, 0, 3'b010, 3'b010, 0, 0, 4'b1100, 4'b0000);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b0000);
    cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b1100);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b1000);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b0000);

    // req_busy forces lock; dropping init_done only forces lock, state stays in run.
    cyc(0, 1, 1, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b1000);
    cyc(0, 0, 0, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b1000);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b0000);

    // Block via port 2 while port 0 is accepted.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3'b101, 3'b001, 0, 0, 4'b1100, 4'b0000);
    cyc(0, 1, 0, 3'b101, 3'b001, 0, 0, 4'b1100, 4'b1100);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b1000);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1100, 4'b0000);

`ifdef BP_LCE_LOCK_STATS_EN
    checks++;
    if (bus.timeout_count_o !== 32'd3) begin
      failures++;
      $display("FAIL timeout_count got=%0d want=3", bus.timeout_count_o);
    end
`endif

    // Credits: fill, overflow attempt, simultaneous at full, drain, underflow attempt.
    cyc(0, 1, 0, 3'b000, 3'b000, 1, 0, 4'b1111, 4'b0001);
    cyc(0, 1, 0, 3'b000, 3'b000, 1, 0, 4'b1111, 4'b0000);
    cyc(0, 1, 0, 3'b000, 3'b000, 1, 0, 4'b1111, 4'b0010);
    cyc(0, 1, 0, 3'b000, 3'b000, 1, 1, 4'b1111, 4'b0010);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1111, 4'b0010);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 1, 4'b1111, 4'b0010);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 1, 4'b1111, 4'b0000);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1111, 4'b0001);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 1, 4'b1111, 4'b0001);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1111, 4'b0001);

    // One credit outstanding, time out, then reset inside e_lock.
    cyc(0, 1, 0, 3'b000, 3'b000, 1, 0, 4'b1111, 4'b0001);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1111, 4'b0000);
    cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1111, 4'b1100);
    cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1111, 4'b1000);
    cyc(1, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1111, 4'b1000);
    cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1111, 4'b1001);
    cyc(0, 1, 0, 3'b000, 3'b000, 0, 0, 4'b1111, 4'b0001);

    // Reset with the blocked count at the limit: no pulse, and counting starts over.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b0000);
    cyc(1, 1, 0, 3'b010, 3'b000, 0, 0, 4'b0100, 4'b0000);
    cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1111, 4'b1001);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b0000);
    cyc(0, 1, 0, 3'b010, 3'b000, 0, 0, 4'b1100, 4'b1100);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
